// File: rtl/present_enc_iter.sv
// Round-iterative PRESENT encryption engine: one full round per clock, valid/ready on both sides.
// Define PRESENT_KEY128_EN for the 128-bit key schedule; the default build uses an 80-bit key.
module present_enc_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_pt,
`ifdef PRESENT_KEY128_EN
  input  logic [127:0] in_key,
`else
  input  logic [79:0]  in_key,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_ct,
  output logic        busy
);

`ifdef PRESENT_KEY128_EN
  localparam int KW = 128;
`else
  localparam int KW = 80;
`endif

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [63:0]   st;
  logic [KW-1:0] kr;
  logic [4:0]    rc;
  logic [63:0]   rk;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [63:0] sbox16(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 16; i++) begin
      y[4*i +: 4] = sbox(x[4*i +: 4]);
    end
    return y;
  endfunction

  // Bit i moves to position 16*i mod 63; bit 63 stays in place.
  function automatic logic [63:0] perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 63; i++) begin
      y[(i * 16) % 63] = x[i];
    end
    y[63] = x[63];
    return y;
  endfunction

  function automatic logic [KW-1:0] key_update(input logic [KW-1:0] k, input logic [4:0] c);
    logic [KW-1:0] t;
`ifdef PRESENT_KEY128_EN
    t = {k[66:0], k[127:67]};
    t[127:124] = sbox(t[127:124]);
    t[123:120] = sbox(t[123:120]);
    t[66:62]   = t[66:62] ^ c;
`else
    t = {k[18:0], k[79:19]};
    t[79:76] = sbox(t[79:76]);
    t[19:15] = t[19:15] ^ c;
`endif
    return t;
  endfunction

  assign rk = kr[KW-1:KW-64];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ROUND;
      end
      ROUND: begin
        busy = 1'b1;
        if (rc == 5'd31) state_nxt = FINAL;
      end
      FINAL: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // rc holds at 31 on the last round so it never wraps back to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= '0;
      kr        <= '0;
      rc        <= '0;
      out_ct    <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            st <= in_pt;
            kr <= in_key;
            rc <= 5'd1;
          end
        end
        ROUND: begin
          st <= perm(sbox16(st ^ rk));
          kr <= key_update(kr, rc);
          if (rc != 5'd31) rc <= rc + 5'd1;
        end
        FINAL: begin
          out_ct    <= st ^ rk;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_present_enc_iter.sv
// Scoreboard bench for present_enc_iter: directed PRESENT vectors, latency, back-pressure, reset abort, throughput.
module tb_present_enc_iter;

`ifdef PRESENT_KEY128_EN
  localparam int KW = 128;
`else
  localparam int KW = 80;
`endif

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_pt;
  logic [KW-1:0] in_key;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_ct;
  logic          busy;

  typedef struct {
    logic [63:0] ct;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   checks;
  int   errors;

  present_enc_iter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pt    (in_pt),
    .in_key   (in_key),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ct   (out_ct),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request and wait (bounded) for acceptance; expectation is queued with its acceptance edge.
  task automatic applyStimulus(input logic [63:0] pt, input logic [KW-1:0] key,
                               input logic [63:0] ct, input bit hold, output int acc);
    int n;
    in_pt    = pt;
    in_key   = key;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    acc = cyc + 1;
    if (!in_ready) begin
      checkOutput("accept_timeout", 64'(in_ready), 64'd1);
    end else begin
      sb.push_back('{ct: ct, acc: acc});
    end
    step();
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      step();
      n++;
    end
    if (sb.size() != 0) begin
      checkOutput("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    step();
  endtask

  // Monitor: latency on out_valid rise, stability while stalled, ciphertext on each transfer.
  initial begin
    logic        prev_valid;
    logic [63:0] held;
    prev_valid = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
      end else begin
        if (out_valid && !prev_valid) begin
          if (sb.size() == 0) checkOutput("unexpected_result", out_ct, 64'd0);
          else checkOutput("latency", 64'(cyc - sb[0].acc), 64'd32);
        end
        if (out_valid && prev_valid) checkOutput("stall_stable", out_ct, held);
        if (out_valid && out_ready && sb.size() != 0) begin
          checkOutput("ciphertext", out_ct, sb[0].ct);
          void'(sb.pop_front());
        end
        prev_valid = out_valid;
        held       = out_ct;
      end
    end
  end

  initial begin
    int acc;
    int prev_acc;
    logic [63:0]   vpt[4];
    logic [KW-1:0] vkey[4];
    logic [63:0]   vct[4];
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_pt     = '0;
    in_key    = '0;
    out_ready = 1'b1;
    #1;
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_ct", out_ct, 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

`ifdef PRESENT_KEY128_EN
    $display("[TB] 128-bit key: pt=0 key=0");
    applyStimulus(64'd0, '0, 64'h96DB702A2E6900AF, 1'b0, acc);
    checkOutput("busy_in_round", 64'(busy), 64'd1);
    checkOutput("in_ready_busy", 64'(in_ready), 64'd0);
    waitDrain();
`else
    $display("[TB] vector pt=0 key=0");
    applyStimulus(64'd0, '0, 64'h5579C1387B228445, 1'b0, acc);
    checkOutput("busy_in_round", 64'(busy), 64'd1);
    checkOutput("in_ready_busy", 64'(in_ready), 64'd0);
    waitDrain();

    $display("[TB] vector pt=ones key=ones");
    applyStimulus('1, '1, 64'h3333DCD3213210D2, 1'b0, acc);
    waitDrain();

    $display("[TB] back-pressure");
    out_ready = 1'b0;
    applyStimulus(64'd0, '1, 64'hE72C46C0F5945049, 1'b0, acc);
    for (int n = 0; n < 60 && !out_valid; n++) step();
    checkOutput("bp_out_valid_seen", 64'(out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_pt    = '1;
      in_key   = '0;
      step();
      checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
      checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_out_ct", out_ct, 64'hE72C46C0F5945049);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    checkOutput("bp_in_ready_after", 64'(in_ready), 64'd1);
    checkOutput("bp_out_valid_after", 64'(out_valid), 64'd0);
    checkOutput("bp_queue_empty", 64'(sb.size()), 64'd0);
    step();
    checkOutput("bp_not_busy", 64'(busy), 64'd0);

    $display("[TB] reset mid-operation");
    applyStimulus(64'd0, '0, 64'h5579C1387B228445, 1'b0, acc);
    repeat (14) step();
    checkOutput("abort_busy_before", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
    checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
    checkOutput("abort_out_ct", out_ct, 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    sb.delete();
    step();
    rst_n = 1'b1;
    step();
    applyStimulus('1, '0, 64'hA112FFC72F68417B, 1'b0, acc);
    waitDrain();

    $display("[TB] back-to-back throughput");
    vpt[0] = 64'd0; vkey[0] = '0; vct[0] = 64'h5579C1387B228445;
    vpt[1] = '1;    vkey[1] = '1; vct[1] = 64'h3333DCD3213210D2;
    vpt[2] = 64'd0; vkey[2] = '1; vct[2] = 64'hE72C46C0F5945049;
    vpt[3] = '1;    vkey[3] = '0; vct[3] = 64'hA112FFC72F68417B;
    prev_acc = 0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(vpt[k], vkey[k], vct[k], 1'b1, acc);
      if (k > 0) checkOutput("b2b_spacing", 64'(acc - prev_acc), 64'd34);
      prev_acc = acc;
    end
    in_valid = 1'b0;
    waitDrain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/present_enc_iter.md
# present_enc_iter

Round-iterative PRESENT-80 encryption engine. It sequences the existing `key_addition`, `sbox` (×16 data plus ×1 key schedule) and `perm` datapath modules, executing one full round per clock. It sits between a plaintext producer and a ciphertext consumer. Both sides use valid/ready handshakes, so blocks are accepted and returned one at a time with back-pressure.

## Interface

Parameters: none.

Ports:
- `clk`  in  1  — system clock; all state updates on the rising edge.
- `rst_n`  in  1  — reset, asynchronous and active-low.
- `in_valid`  in  1  — `in_pt`/`in_key` hold a request.
- `in_ready`  out  1  — engine can accept a request (IDLE only).
- `in_pt`  in  64  — plaintext block.
- `in_key`  in  80  — cipher key (128 when `PRESENT_KEY128_EN` is set).
- `out_valid`  out  1  — `out_ct` holds a result.
- `out_ready`  in  1  — consumer accepts the result.
- `out_ct`  out  64  — ciphertext.
- `busy`  out  1  — high in LOAD-free states ROUND and FINAL.

## Operation

Internal registers:
- `st` — 64-bit state.
- `kr` — 80-bit (or 128-bit) key register.
- `rc` — 5-bit round counter.
- FSM with states IDLE, ROUND, FINAL, DONE.

Behaviour by state:
- **IDLE:** `in_ready`=1. On `in_valid & in_ready`: `st`←`in_pt`, `kr`←`in_key`, `rc`←1, go to ROUND.
- **ROUND**, one round per cycle:
  - `st` ← `perm(sbox16(st ^ kr[79:16]))`.
  - `kr` ← key update using `rc`.
  - `rc` ← `rc`+1.
  - When `rc`==31 this update is the last round; go to FINAL.
- **80-bit key update:**
  - `t` = `kr` rotated left 61.
  - `t[79:76]` = `sbox(t[79:76])`.
  - `t[19:15]` ^= `rc`.
- **FINAL:** `out_ct` register ← `st ^ kr[79:16]` (whitening with K32), `out_valid`←1, go to DONE.
- **DONE:** hold `out_ct` and `out_valid`=1 until `out_ready`=1. On that edge `out_valid`←0 and return to IDLE.
- **Consumer stall:** `out_ct` stays stable while `out_valid`=1 and `out_ready`=0.
- **Counter width:** `rc` is 5 bits and never wraps in operation (max 31). The value 0 is never XORed into the key.
- **Request during busy:** `in_valid` in any non-IDLE state is ignored; `in_ready`=0, and inputs are not sampled.
- **Early `out_ready`:** `out_ready` outside DONE has no effect.

## Timing

Reset (`rst_n`=0, asynchronous), applied immediately:
- FSM=IDLE.
- `in_ready`=1.
- `out_valid`=0.
- `out_ct`=0.
- `busy`=0.
- `st`, `kr`, `rc` = 0.

Latency and throughput:
- Acceptance edge is E0. Rounds complete on edges E1…E31, FINAL writes at E32, and `out_valid`=1 is visible from E32.
- Latency is 32 cycles from acceptance to `out_valid`.
- With `out_ready` tied high: `out_valid` lasts 1 cycle, the engine is back in IDLE after E33, and the next acceptance is possible at E33 + 1 cycle. Throughput is 1 block / 34 cycles.

Handshake rules:
- `in_ready` is a pure function of state (IDLE), not of `in_valid`.
- Results are never dropped or overwritten before acceptance.

Reset during operation:
- Reset asserted mid-ROUND or in DONE aborts the block.
- After release, the engine is in IDLE with `out_valid`=0; no partial result ever appears.
- Reset release is synchronised by the reset tree and is not this block's concern.

## Configuration

`PRESENT_KEY128_EN` selects the key width.

- **Undefined (default):** 80-bit key. `in_key`/`kr` are 80 bits, using the update above.
- **Defined:** PRESENT-128. `in_key`/`kr` are 128 bits, and the round key is `kr[127:64]`. The key update is:
  - `t` = `kr` rotated left 61.
  - `t[127:124]` = `sbox(t[127:124])`.
  - `t[123:120]` = `sbox(t[123:120])`.
  - `t[66:62]` ^= `rc`.
- Timing, latency and handshake are identical in both builds.

## Test plan

- **80-bit vector:** `in_pt`=0, `in_key`=0, `out_ready`=1 → `out_ct`=64'h5579C1387B228445, `out_valid` rises exactly 32 cycles after acceptance.
- **80-bit vector:** `in_pt`=64'hFFFFFFFFFFFFFFFF, `in_key`=80'hFFFF…FFFF → `out_ct`=64'h3333DCD3213210D2.
- **Back-pressure:** `in_pt`=0, `in_key`=80'hFF…FF, `out_ready`=0 for 10 cycles → `out_ct`=64'hE72C46C0F5945049 stable with `out_valid`=1 throughout. A new `in_valid` in that window is ignored (`in_ready`=0). Releasing `out_ready` gives one transfer, and `in_ready` is 1 on the next cycle.
- **Reset mid-operation:** pull `rst_n` low at round 15 → outputs are at reset values immediately. A fresh request (pt 64'hFF…FF, key 0) then yields 64'hA112FFC72F68417B with full 32-cycle latency.
- **Back-to-back throughput:** with `in_valid` and `out_ready` held high, 4 consecutive blocks complete at 34-cycle spacing, each with correct ciphertext.
- **128-bit build** (`PRESENT_KEY128_EN`): pt=0, key=0 → `out_ct`=64'h96DB702A2E6900AF, latency 32.
